dmem_responder: RTL and testbench

Data-memory responder for the Y86-64 processor: the memory-side end of the data access interface that the memory stage drives for rmmovq/pushq/call writes and mrmovq/popq/ret reads. It accepts one 8-byte access at a time over a valid/ready request channel and returns read data and status over a valid/ready response channel. Its latency is programmable, so the memory stage can be exercised against realistic stall behaviour. Bad addresses are reported as an error flag that the pipeline maps to status SADR.

---
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Y86-64 data-memory responder, one 8-byte access at a time with
//            programmable response latency and address-error reporting.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 2048,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [63:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               accept;
    logic               addr_err;
    logic [IDX_W-1:0]   idx;

    assign accept     = req_valid && (state_q == IDLE);
    assign addr_err   = (req_addr[2:0] != 3'b000) || (req_addr >= ADDR_LIMIT);
    assign idx        = req_addr[IDX_W+2:3];

    assign req_ready  = (state_q == IDLE) && rst_n;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d   = addr_err;
                    rdata_d = (!req_write && !addr_err) ? mem[idx] : 64'd0;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Data and error stay frozen until the requester takes them.
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; writes commit on the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst_n && accept && req_write && !addr_err) begin
            mem[idx] <= req_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Scoreboard bench: dut0 runs at LATENCY=2, dut1 at LATENCY=1 for back-to-back traffic.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rv0, rr0, rw0, pv0, pr0, pe0;
    logic [63:0] ra0, rwd0, prd0;
    logic        rv1, rr1, rw1, pv1, pr1, pe1;
    logic [63:0] ra1, rwd1, prd1;

    dmem_responder #(.DEPTH(2048), .LATENCY(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv0), .req_ready(rr0), .req_write(rw0),
        .req_addr(ra0), .req_wdata(rwd0),
        .resp_valid(pv0), .resp_ready(pr0), .resp_rdata(prd0), .resp_err(pe0)
    );

    dmem_responder #(.DEPTH(2048), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv1), .req_ready(rr1), .req_write(rw1),
        .req_addr(ra1), .req_wdata(rwd1),
        .resp_valid(pv1), .resp_ready(pr1), .resp_rdata(prd1), .resp_err(pe1)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && pv0 && pr0) begin
            if (q0.size() == 0) begin
                chk("unexpected_resp0", 64'd1, 64'd0);
            end else begin
                e0 = q0.pop_front();
                chk("rdata0", prd0, e0.rdata);
                chk("err0", 64'(pe0), 64'(e0.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && pv1 && pr1) begin
            if (q1.size() == 0) begin
                chk("unexpected_resp1", 64'd1, 64'd0);
            end else begin
                e1 = q1.pop_front();
                chk("rdata1", prd1, e1.rdata);
                chk("err1", 64'(pe1), 64'(e1.err));
            end
        end
    end

    task automatic issue0(input logic w, input logic [63:0] a, input logic [63:0] d);
        int n;
        n = 0;
        rv0 = 1'b1; rw0 = w; ra0 = a; rwd0 = d;
        do begin
            @(negedge clk);
            n++;
        end while (!rr0 && n < 50);
        if (!rr0) chk("accept_timeout0", 64'd0, 64'd1);
        @(posedge clk);
        #1 rv0 = 1'b0;
    endtask

    task automatic txn0(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] erd, input logic eerr, input int bp);
        int n;
        q0.push_back('{rdata: erd, err: eerr});
        pr0 = (bp == 0);
        issue0(w, a, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pv0 && n < 50);
        chk("latency0", 64'(n), 64'd2);
        if (bp > 0) begin
            for (int k = 0; k < bp; k++) begin
                chk("bp_valid0", 64'(pv0), 64'd1);
                chk("bp_rdata0", prd0, erd);
                chk("bp_err0", 64'(pe0), 64'(eerr));
                chk("bp_req_ready0", 64'(rr0), 64'd0);
                if (k < bp - 1) @(negedge clk);
            end
            @(posedge clk);
            #1 pr0 = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("req_ready_after0", 64'(rr0), 64'd1);
        chk("valid_after0", 64'(pv0), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic burst1(input logic w, input logic [63:0] a[4], input logic [63:0] d[4],
                          input logic [63:0] erd[4]);
        int acc[4];
        int n;
        for (int i = 0; i < 4; i++) q1.push_back('{rdata: erd[i], err: 1'b0});
        pr1 = 1'b1;
        rv1 = 1'b1; rw1 = w; ra1 = a[0]; rwd1 = d[0];
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rr1 && n < 50);
            if (!rr1) chk("accept_timeout1", 64'd0, 64'd1);
            acc[i] = cyc;
            @(posedge clk);
            #1;
            if (i < 3) begin
                ra1 = a[i+1]; rwd1 = d[i+1];
            end else begin
                rv1 = 1'b0;
            end
        end
        for (int i = 1; i < 4; i++) chk("b2b_interval1", 64'(acc[i] - acc[i-1]), 64'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("q1_drained", 64'(q1.size()), 64'd0);
    endtask

    logic [63:0] ba[4];
    logic [63:0] bd[4];
    logic [63:0] bz[4];

    initial begin
        rst_n = 1'b0;
        rv0 = 1'b0; rw0 = 1'b0; ra0 = 64'd0; rwd0 = 64'd0; pr0 = 1'b0;
        rv1 = 1'b0; rw1 = 1'b0; ra1 = 64'd0; rwd1 = 64'd0; pr1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid0", 64'(pv0), 64'd0);
        chk("rst_rdata0", prd0, 64'd0);
        chk("rst_err0", 64'(pe0), 64'd0);
        chk("rst_req_ready0", 64'(rr0), 64'd0);
        chk("rst_req_ready1", 64'(rr1), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready0", 64'(rr0), 64'd1);
        @(posedge clk);
        #1;

        // write then read back
        txn0(1'b1, 64'h40, 64'h0123456789ABCDEF, 64'd0, 1'b0, 0);
        txn0(1'b0, 64'h40, 64'd0, 64'h0123456789ABCDEF, 1'b0, 0);

        // misaligned write is suppressed
        txn0(1'b1, 64'h40, 64'h11, 64'd0, 1'b0, 0);
        txn0(1'b1, 64'h43, 64'hFF, 64'd0, 1'b1, 0);
        txn0(1'b0, 64'h40, 64'd0, 64'h11, 1'b0, 0);

        // range boundaries
        txn0(1'b0, 64'h4000, 64'd0, 64'd0, 1'b1, 0);
        txn0(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1, 0);
        txn0(1'b1, 64'h3FF8, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0, 0);
        txn0(1'b0, 64'h3FF8, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 5);

        // LATENCY=1 back-to-back
        ba[0] = 64'h0;    ba[1] = 64'h8;    ba[2] = 64'h3FF8; ba[3] = 64'h100;
        bd[0] = 64'hA1;   bd[1] = 64'hB2;   bd[2] = 64'hC3;   bd[3] = 64'hD4;
        bz[0] = 64'd0;    bz[1] = 64'd0;    bz[2] = 64'd0;    bz[3] = 64'd0;
        burst1(1'b1, ba, bd, bz);
        burst1(1'b0, ba, bz, bd);

        // reset while waiting: response dropped, write kept
        pr0 = 1'b1;
        issue0(1'b1, 64'h80, 64'hAA);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready0", 64'(rr0), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_valid0", 64'(pv0), 64'd0);
            chk("post_rst_req_ready0", 64'(rr0), 64'd1);
        end
        @(posedge clk);
        #1;
        txn0(1'b0, 64'h80, 64'd0, 64'hAA, 1'b0, 0);

        chk("q0_drained", 64'(q0.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
